dc_token_ring_reader: RTL and testbench
=======================================

DC_TOKEN_RING_READER -- requirements
Module: dc_token_ring_reader

Interface
REQ-001 Parameter DATA_WIDTH, default 64, width of one buffered payload word.
REQ-002 Parameter BUFFER_DEPTH, default 8, number of slots in the token ring; SHALL be a power of two, at least 4.
REQ-003 Parameter SYNC_STAGES, default 2, flop depth of the write-token synchronizer; SHALL be at least 2.
REQ-004 clk_i  in  1  reader-domain clock; one clock only.
REQ-005 rst_i  in  1  reset, synchronous, active-high.
REQ-006 isolate_i  in  1  isolation request; 1 = discard mode.
REQ-007 data_async_i  in  DATA_WIDTH*BUFFER_DEPTH  writer-side slot array; slot k = bits [k*DATA_WIDTH +: DATA_WIDTH].
REQ-008 writetoken_async_i  in  BUFFER_DEPTH  one-hot writer token from the foreign domain; bit k = next slot to be written.
REQ-009 readpointer_o  out  BUFFER_DEPTH  one-hot read pointer returned to the writer; registered.
REQ-010 valid_o  out  1  output word valid.
REQ-011 data_o  out  DATA_WIDTH  output word; registered.
REQ-012 ready_i  in  1  downstream accept.
REQ-013 level_o  out  log2(BUFFER_DEPTH)  number of slots visible as filled after synchronization.
REQ-014 token_err_o  out  1  sticky flag: synchronized token was not one-hot.

Function
REQ-015 writetoken_async_i SHALL pass through SYNC_STAGES flops on clk_i; only the last stage (wt_sync) SHALL be used for decisions.
REQ-016 Empty SHALL mean wt_sync == readpointer_o. Full detection is the writer's job; the reader never blocks the writer except through readpointer_o.
REQ-017 The block SHALL have one output register: valid_q and data_q. valid_o = valid_q & ~isolate_i.
REQ-018 Load condition: not empty AND (valid_q == 0 OR ready_i == 1 OR isolate_i == 1).
REQ-019 On load, data_q SHALL take the slot selected by readpointer_o. valid_q SHALL be set to 1. readpointer_o SHALL rotate left by one, with bit BUFFER_DEPTH-1 wrapping to bit 0.
REQ-020 If valid_q == 1, the accept condition is (ready_i OR isolate_i). On accept with no load, valid_q SHALL clear. On accept with a load in the same cycle, valid_q stays 1 and data_q updates, so throughput is one word per cycle.
REQ-021 If valid_q == 1 and neither ready_i nor isolate_i is set, data_q and valid_q SHALL hold. The AXI valid-stable rule applies.
REQ-022 In isolate mode the output is forced ready. Buffered and arriving words are popped and discarded, so the writer never stalls. data_o still updates.
REQ-023 If isolate_i deasserts while valid_q == 1, the held word SHALL be presented on valid_o from the next cycle.
REQ-024 Latency: a token change at the synchronizer input produces valid_o = 1 exactly SYNC_STAGES+1 cycles later, given the output register is free and isolate_i = 0.
REQ-025 level_o = (idx(wt_sync) - idx(readpointer_o)) mod BUFFER_DEPTH. idx() is the one-hot-to-binary index. The result does not include the word held in data_q.
REQ-026 If wt_sync is not one-hot (zero or multiple bits set), token_err_o SHALL set and stay set until reset. While wt_sync is not one-hot, no load SHALL occur.
REQ-027 No combinational path SHALL exist from writetoken_async_i or data_async_i to any output.

Reset
REQ-028 While rst_i == 1 at a clk_i edge, the following SHALL reset together:
- readpointer_o = 1 (slot 0)
- all synchronizer stages = 1 (slot 0)
- valid_q = 0 and data_q = 0
- token_err_o = 0
- level_o therefore reads 0
REQ-029 Reset asserted mid-transfer SHALL drop any held word with no output handshake. valid_o SHALL be 0 in the cycle after the reset edge.

Verification
REQ-030 Single word: write slot0 = 0xA5, token 1->2, ready_i = 1. Required: valid_o = 1 with data_o = 0xA5 three cycles later (SYNC_STAGES = 2); readpointer_o = 2; then valid_o = 0.
REQ-031 Backpressure: 3 words loaded, ready_i = 0 for 10 cycles. Required: data_o holds word 0, level_o = 2, readpointer_o = 2. After ready_i rises, words appear back-to-back over 3 cycles.
REQ-032 Wrap-around: 20 words through BUFFER_DEPTH = 8 with random ready_i. Required: in-order data and pointer sequence 1,2,4,...,128,1 with no loss or duplication.
REQ-033 Isolation: 4 words pending, isolate_i = 1. Required: valid_o = 0, all 4 popped in 4 cycles, level_o = 0. On release with no new data, valid_o stays 0.
REQ-034 Bad token: token forced to 0x03. Required: token_err_o = 1 after SYNC_STAGES cycles, readpointer_o frozen. Clears only via rst_i.
REQ-035 Reset with valid_o = 1 and level_o = 3. Required: next cycle valid_o = 0, readpointer_o = 1, level_o = 0.

Source files
------------

// File: rtl/dc_token_ring_reader.sv
// Reader side of a token-ring clock-domain crossing: synchronizes the writer's
// one-hot token, pops slots in ring order and presents them through one output register.
module dc_token_ring_reader #(
  parameter int DATA_WIDTH   = 64,
  parameter int BUFFER_DEPTH = 8,
  parameter int SYNC_STAGES  = 2
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  input  logic                               isolate_i,
  input  logic [DATA_WIDTH*BUFFER_DEPTH-1:0] data_async_i,
  input  logic [BUFFER_DEPTH-1:0]            writetoken_async_i,
  output logic [BUFFER_DEPTH-1:0]            readpointer_o,
  output logic                               valid_o,
  output logic [DATA_WIDTH-1:0]              data_o,
  input  logic                               ready_i,
  output logic [$clog2(BUFFER_DEPTH)-1:0]    level_o,
  output logic                               token_err_o
);

  localparam int LW = $clog2(BUFFER_DEPTH);
  localparam logic [BUFFER_DEPTH-1:0] SLOT0 = BUFFER_DEPTH'(1);

  logic [SYNC_STAGES-1:0][BUFFER_DEPTH-1:0] wt_pipe;
  logic [BUFFER_DEPTH-1:0] wt_sync;
  logic [DATA_WIDTH-1:0]   rd_word;
  logic [DATA_WIDTH-1:0]   data_q;
  logic                    valid_q;
  logic                    err_q;
  logic                    wt_ok;
  logic                    empty;
  logic                    load;

  function automatic logic [LW-1:0] idx(input logic [BUFFER_DEPTH-1:0] oh);
    logic [LW-1:0] r;
    r = '0;
    for (int k = 0; k < BUFFER_DEPTH; k++)
      if (oh[k]) r = r | LW'(k);
    return r;
  endfunction

  // Stage 0 is the only flop that sees the foreign-domain token.
  always_ff @(posedge clk_i) begin
    if (rst_i) wt_pipe <= {SYNC_STAGES{SLOT0}};
    else       wt_pipe <= {wt_pipe[SYNC_STAGES-2:0], writetoken_async_i};
  end

  assign wt_sync = wt_pipe[SYNC_STAGES-1];
  assign wt_ok   = $onehot(wt_sync);
  assign empty   = (wt_sync == readpointer_o);
  assign load    = wt_ok && !empty && (!valid_q || ready_i || isolate_i);

  always_comb begin
    rd_word = '0;
    for (int k = 0; k < BUFFER_DEPTH; k++)
      if (readpointer_o[k]) rd_word = rd_word | data_async_i[k*DATA_WIDTH +: DATA_WIDTH];
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      readpointer_o <= SLOT0;
      valid_q       <= 1'b0;
      data_q        <= '0;
      err_q         <= 1'b0;
    end else begin
      if (!wt_ok) err_q <= 1'b1;
      if (load) begin
        data_q        <= rd_word;
        valid_q       <= 1'b1;
        readpointer_o <= {readpointer_o[BUFFER_DEPTH-2:0], readpointer_o[BUFFER_DEPTH-1]};
      end else if (valid_q && (ready_i || isolate_i)) begin
        valid_q <= 1'b0;
      end
    end
  end

  // Isolation discards words, so it hides valid but never the data register.
  assign valid_o     = valid_q & ~isolate_i;
  assign data_o      = data_q;
  assign level_o     = idx(wt_sync) - idx(readpointer_o);
  assign token_err_o = err_q | ~wt_ok;

endmodule

// File: tb/tb_dc_token_ring_reader.sv
// Bench for dc_token_ring_reader: a writer model fills the ring and a queue of
// written words predicts the ordered output stream.
module tb_dc_token_ring_reader;
  localparam int DW = 64;
  localparam int D  = 8;

  logic            clk = 1'b0;
  logic            rst_i;
  logic            isolate_i;
  logic [DW*D-1:0] data_async;
  logic [D-1:0]    writetoken;
  logic [D-1:0]    readpointer_o;
  logic            valid_o;
  logic [DW-1:0]   data_o;
  logic            ready_i;
  logic [2:0]      level_o;
  logic            token_err_o;

  int vectors = 0;
  int fails   = 0;
  int wr_idx  = 0;
  logic [DW-1:0] exp_q[$];

  dc_token_ring_reader #(.DATA_WIDTH(DW), .BUFFER_DEPTH(D), .SYNC_STAGES(2)) dut (
    .clk_i(clk), .rst_i(rst_i), .isolate_i(isolate_i),
    .data_async_i(data_async), .writetoken_async_i(writetoken),
    .readpointer_o(readpointer_o), .valid_o(valid_o), .data_o(data_o),
    .ready_i(ready_i), .level_o(level_o), .token_err_o(token_err_o)
  );

  always #5 clk = ~clk;

  function automatic int ptr_idx(input logic [D-1:0] p);
    int r = 0;
    for (int k = 0; k < D; k++) if (p[k]) r = k;
    return r;
  endfunction

  task automatic tick();
    @(negedge clk); #1;
  endtask

  task automatic write_word(input logic [DW-1:0] v);
    data_async[wr_idx*DW +: DW] = v;
    wr_idx     = (wr_idx + 1) % D;
    writetoken = D'(1) << wr_idx;
    exp_q.push_back(v);
  endtask

  task automatic do_reset();
    rst_i = 1'b1; isolate_i = 1'b0; ready_i = 1'b0;
    writetoken = D'(1); data_async = '0; wr_idx = 0;
    exp_q.delete();
    tick(); tick();
    rst_i = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    vectors++; if (valid_o !== 1'b0) begin fails++; $display("FAIL reset_valid got=%b want=0", valid_o); end
    vectors++; if (readpointer_o !== 8'h01) begin fails++; $display("FAIL reset_rp got=%h want=01", readpointer_o); end
    vectors++; if (level_o !== 3'd0) begin fails++; $display("FAIL reset_level got=%0d want=0", level_o); end
    vectors++; if (token_err_o !== 1'b0) begin fails++; $display("FAIL reset_err got=%b want=0", token_err_o); end
    vectors++; if (data_o !== 64'h0) begin fails++; $display("FAIL reset_data got=%h want=0", data_o); end
  endtask

  task automatic test_single();
    do_reset();
    ready_i = 1'b1;
    write_word(64'hA5);
    for (int c = 1; c <= 2; c++) begin
      tick();
      vectors++; if (valid_o !== 1'b0) begin fails++; $display("FAIL single_early c=%0d got=%b want=0", c, valid_o); end
    end
    tick();
    vectors++; if (valid_o !== 1'b1) begin fails++; $display("FAIL single_valid got=%b want=1", valid_o); end
    vectors++; if (data_o !== 64'hA5) begin fails++; $display("FAIL single_data got=%h want=a5", data_o); end
    vectors++; if (readpointer_o !== 8'h02) begin fails++; $display("FAIL single_rp got=%h want=02", readpointer_o); end
    vectors++; if (level_o !== 3'd0) begin fails++; $display("FAIL single_level got=%0d want=0", level_o); end
    tick();
    vectors++; if (valid_o !== 1'b0) begin fails++; $display("FAIL single_drop got=%b want=0", valid_o); end
  endtask

  task automatic test_backpressure();
    do_reset();
    for (int i = 0; i < 3; i++) write_word({$urandom, $urandom});
    repeat (13) tick();
    vectors++; if (valid_o !== 1'b1) begin fails++; $display("FAIL bp_valid got=%b want=1", valid_o); end
    vectors++; if (data_o !== exp_q[0]) begin fails++; $display("FAIL bp_hold got=%h want=%h", data_o, exp_q[0]); end
    vectors++; if (level_o !== 3'd2) begin fails++; $display("FAIL bp_level got=%0d want=2", level_o); end
    vectors++; if (readpointer_o !== 8'h02) begin fails++; $display("FAIL bp_rp got=%h want=02", readpointer_o); end
    for (int i = 0; i < 3; i++) begin
      ready_i = 1'b1; #1;
      vectors++;
      if (valid_o !== 1'b1 || data_o !== exp_q[i]) begin
        fails++; $display("FAIL bp_burst i=%0d got=%b/%h want=1/%h", i, valid_o, data_o, exp_q[i]);
      end
      tick();
    end
    vectors++; if (valid_o !== 1'b0) begin fails++; $display("FAIL bp_end got=%b want=0", valid_o); end
    vectors++; if (level_o !== 3'd0) begin fails++; $display("FAIL bp_end_level got=%0d want=0", level_o); end
  endtask

  task automatic test_wrap();
    int n_wr = 0, n_rd = 0, cyc = 0;
    logic [D-1:0]  prev;
    logic [D-1:0]  nxt;
    logic [DW-1:0] want;
    do_reset();
    prev = readpointer_o;
    while (n_rd < 20 && cyc < 2000) begin
      if (n_wr < 20 && $urandom_range(0, 2) != 0 && ((wr_idx + 1) % D) != ptr_idx(readpointer_o)) begin
        write_word({$urandom, $urandom});
        n_wr++;
      end
      ready_i = 1'($urandom_range(0, 1));
      #1;
      if (valid_o && ready_i) begin
        vectors++;
        if (exp_q.size() == 0) begin
          fails++; $display("FAIL wrap_extra got=%h want=none", data_o);
        end else begin
          want = exp_q.pop_front();
          if (data_o !== want) begin fails++; $display("FAIL wrap_data n=%0d got=%h want=%h", n_rd, data_o, want); end
        end
        n_rd++;
      end
      if (readpointer_o !== prev) begin
        nxt = D'(1) << ((ptr_idx(prev) + 1) % D);
        vectors++;
        if (readpointer_o !== nxt) begin fails++; $display("FAIL wrap_rp got=%h want=%h", readpointer_o, nxt); end
        prev = readpointer_o;
      end
      tick();
      cyc++;
    end
    vectors++; if (n_rd != 20) begin fails++; $display("FAIL wrap_timeout got=%0d want=20", n_rd); end
    ready_i = 1'b1;
    tick();
    vectors++; if (readpointer_o !== 8'h10) begin fails++; $display("FAIL wrap_final_rp got=%h want=10", readpointer_o); end
    vectors++; if (valid_o !== 1'b0 || level_o !== 3'd0) begin
      fails++; $display("FAIL wrap_drain got=%b/%0d want=0/0", valid_o, level_o);
    end
  endtask

  task automatic test_isolate();
    do_reset();
    for (int i = 0; i < 4; i++) write_word({$urandom, $urandom});
    repeat (3) tick();
    vectors++; if (valid_o !== 1'b1 || level_o !== 3'd3) begin
      fails++; $display("FAIL iso_pre got=%b/%0d want=1/3", valid_o, level_o);
    end
    isolate_i = 1'b1; #1;
    vectors++; if (valid_o !== 1'b0) begin fails++; $display("FAIL iso_mask got=%b want=0", valid_o); end
    repeat (4) tick();
    vectors++; if (level_o !== 3'd0) begin fails++; $display("FAIL iso_level got=%0d want=0", level_o); end
    vectors++; if (readpointer_o !== 8'h10) begin fails++; $display("FAIL iso_rp got=%h want=10", readpointer_o); end
    vectors++; if (data_o !== exp_q[3]) begin fails++; $display("FAIL iso_data got=%h want=%h", data_o, exp_q[3]); end
    isolate_i = 1'b0; #1;
    for (int c = 0; c < 3; c++) begin
      vectors++; if (valid_o !== 1'b0) begin fails++; $display("FAIL iso_release c=%0d got=%b want=0", c, valid_o); end
      tick();
    end
  endtask

  task automatic test_bad_token();
    do_reset();
    writetoken = 8'h03;
    tick();
    vectors++; if (token_err_o !== 1'b0) begin fails++; $display("FAIL bad_early got=%b want=0", token_err_o); end
    tick();
    vectors++; if (token_err_o !== 1'b1) begin fails++; $display("FAIL bad_flag got=%b want=1", token_err_o); end
    repeat (5) tick();
    vectors++; if (readpointer_o !== 8'h01 || valid_o !== 1'b0) begin
      fails++; $display("FAIL bad_frozen got=%h/%b want=01/0", readpointer_o, valid_o);
    end
    writetoken = 8'h01;
    repeat (4) tick();
    vectors++; if (token_err_o !== 1'b1) begin fails++; $display("FAIL bad_sticky got=%b want=1", token_err_o); end
    do_reset();
    #1;
    vectors++; if (token_err_o !== 1'b0) begin fails++; $display("FAIL bad_clear got=%b want=0", token_err_o); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 4; i++) write_word({$urandom, $urandom});
    repeat (3) tick();
    vectors++; if (valid_o !== 1'b1 || level_o !== 3'd3) begin
      fails++; $display("FAIL mid_pre got=%b/%0d want=1/3", valid_o, level_o);
    end
    rst_i = 1'b1; writetoken = 8'h01; wr_idx = 0; exp_q.delete();
    tick();
    rst_i = 1'b0;
    vectors++; if (valid_o !== 1'b0) begin fails++; $display("FAIL mid_valid got=%b want=0", valid_o); end
    vectors++; if (readpointer_o !== 8'h01) begin fails++; $display("FAIL mid_rp got=%h want=01", readpointer_o); end
    vectors++; if (level_o !== 3'd0) begin fails++; $display("FAIL mid_level got=%0d want=0", level_o); end
  endtask

  initial begin
    rst_i = 1'b1; isolate_i = 1'b0; ready_i = 1'b0;
    writetoken = 8'h01; data_async = '0;
    test_reset();
    test_single();
    test_backpressure();
    test_wrap();
    test_isolate();
    test_bad_token();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end
endmodule
